// File: rtl/addr8s_pkg.sv
// rtl/addr8s_pkg.sv - shared types, defaults and mod-3 helper for the adder residue checker
package addr8s_pkg;

   localparam int DEF_W            = 8;
   localparam int DEF_CNT_W        = 8;
   localparam int DEF_ALARM_THRESH = 3;

   typedef enum logic [1:0] {
      OK      = 2'd0,
      SUSPECT = 2'd1,
      ALARM   = 2'd2
   } chk_state_t;

   // Bit i weighs 2^i mod 3 (1,2,1,2..); the sign bit weighs -2^W mod 3.
   function automatic logic [1:0] res3(input logic [DEF_W:0] x);
      int acc;
      acc = 0;
      for (int i = 0; i < DEF_W; i++) begin
         if (x[i]) acc += ((i % 2) == 0) ? 1 : 2;
      end
      if (x[DEF_W]) acc += ((DEF_W % 2) == 0) ? 2 : 1;
      return 2'(acc % 3);
   endfunction

endpackage

// File: rtl/addr8s_residue_chk_if.sv
// rtl/addr8s_residue_chk_if.sv - operand/result input stream and checked-result output stream
interface addr8s_residue_chk_if
   import addr8s_pkg::*;
#(
   parameter int W = DEF_W
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W:0]   sum;
   logic         out_valid;
   logic         out_ready;
   logic [W:0]   out_sum;
   logic         out_err;

   modport master (
      output in_valid, a, b, sum, out_ready,
      input  in_ready, out_valid, out_sum, out_err
   );

   modport slave (
      input  in_valid, a, b, sum, out_ready,
      output in_ready, out_valid, out_sum, out_err
   );
endinterface

// File: rtl/res3_unit.sv
// rtl/res3_unit.sv - combinational mod-3 reducer for a (W+1)-bit two's complement value
module res3_unit
   import addr8s_pkg::*;
#(
   parameter int W = DEF_W
) (
   input  logic [W:0] x_i,
   output logic [1:0] r_o
);
   int acc;

   always_comb begin
      acc = 0;
      for (int i = 0; i < W; i++) begin
         if (x_i[i]) acc += ((i % 2) == 0) ? 1 : 2;
      end
      // Negative weight of the sign bit folded into a positive residue.
      if (x_i[W]) acc += ((W % 2) == 0) ? 2 : 1;
      r_o = 2'(acc % 3);
   end
endmodule

// File: rtl/addr8s_residue_chk.sv
// rtl/addr8s_residue_chk.sv - two-stage mod-3 residue checker with error accounting and sticky alarm
module addr8s_residue_chk
   import addr8s_pkg::*;
#(
   parameter int W            = DEF_W,
   parameter int CNT_W        = DEF_CNT_W,
   parameter int ALARM_THRESH = DEF_ALARM_THRESH
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clr_i,
   addr8s_residue_chk_if.slave  bus,
   output logic                 alarm_o,
   output logic [CNT_W-1:0]     err_cnt_o
);
   localparam int CW = (ALARM_THRESH < 1) ? 1 : $clog2(ALARM_THRESH + 1);
   localparam logic [CW-1:0] THR = CW'(ALARM_THRESH);

   logic         stall;
   logic         s1_valid_q;
   logic [W-1:0] a_q, b_q;
   logic [W:0]   sum_q;
   logic         out_valid_q, out_err_q;
   logic [W:0]   out_sum_q;
   logic [1:0]   r_a, r_b, r_s;
   logic [2:0]   r_ab;
   logic         err;
   logic         hs;

   chk_state_t     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CW-1:0]    consec_q, consec_d;
   logic             alarm_q;

   assign stall        = out_valid_q & ~bus.out_ready;
   assign bus.in_ready = ~stall;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid_q  <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_err_q   <= 1'b0;
      end else if (!stall) begin
         s1_valid_q  <= bus.in_valid;
         if (bus.in_valid) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            sum_q <= bus.sum;
         end
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            out_sum_q <= sum_q;
            out_err_q <= err;
         end
      end
   end

   res3_unit #(.W(W)) u_res_a (.x_i({a_q[W-1], a_q}), .r_o(r_a));
   res3_unit #(.W(W)) u_res_b (.x_i({b_q[W-1], b_q}), .r_o(r_b));
   res3_unit #(.W(W)) u_res_s (.x_i(sum_q),           .r_o(r_s));

   always_comb begin
      r_ab = {1'b0, r_a} + {1'b0, r_b};
      if (r_ab >= 3'd3) r_ab = r_ab - 3'd3;
      err = (r_ab[1:0] != r_s);
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = out_sum_q;
   assign bus.out_err   = out_err_q;

   // Each result is accounted exactly once, on its output handshake.
   assign hs = out_valid_q & bus.out_ready;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      consec_d = consec_q;
      if (clr_i) begin
         state_d  = OK;
         cnt_d    = '0;
         consec_d = '0;
      end else if (hs) begin
         if (out_err_q) begin
            if (cnt_q != '1)     cnt_d    = cnt_q + 1'b1;
            if (consec_q != THR) consec_d = consec_q + 1'b1;
         end else begin
            consec_d = '0;
         end
         unique case (state_q)
            OK: begin
               if (out_err_q) state_d = (consec_d >= THR) ? ALARM : SUSPECT;
            end
            SUSPECT: begin
               if (!out_err_q)            state_d = OK;
               else if (consec_d >= THR)  state_d = ALARM;
            end
            ALARM:   state_d = ALARM;
            default: state_d = OK;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= OK;
         cnt_q    <= '0;
         consec_q <= '0;
         alarm_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         consec_q <= consec_d;
         alarm_q  <= (state_d == ALARM);
      end
   end

   assign alarm_o   = alarm_q;
   assign err_cnt_o = cnt_q;
endmodule

// File: tb/tb_addr8s_residue_chk.sv
// tb/tb_addr8s_residue_chk.sv - directed and randomized self-checking bench for addr8s_residue_chk
module tb_addr8s_residue_chk;
   localparam int W      = 8;
   localparam int CNT_W  = 8;
   localparam int THRESH = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             clr = 1'b0;
   logic             alarm;
   logic [CNT_W-1:0] err_cnt;

   addr8s_residue_chk_if #(.W(W)) bus();

   addr8s_residue_chk #(.W(W), .CNT_W(CNT_W), .ALARM_THRESH(THRESH)) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .clr_i    (clr),
      .bus      (bus.slave),
      .alarm_o  (alarm),
      .err_cnt_o(err_cnt)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [W:0] q_sum[$];
   logic       q_err[$];
   int         exp_cnt = 0;
   int         consec = 0;
   logic       exp_alarm = 1'b0;
   int         n_in = 0;
   int         n_out = 0;

   function automatic logic model_err(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [W:0] s);
      int d;
      d = int'($signed(a)) + int'($signed(b)) - int'($signed(s));
      return (d % 3) != 0;
   endfunction

   function automatic logic [W:0] good_sum(input logic [W-1:0] a, input logic [W-1:0] b);
      int t;
      t = int'($signed(a)) + int'($signed(b));
      return t[W:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference: scoreboard of expected results plus error-history rules.
   always @(negedge clk) begin
      if (rst_n) begin
         logic e;
         logic have;
         have = 1'b0;
         e    = 1'b0;
         chk("err_cnt", 32'(err_cnt), exp_cnt);
         chk("alarm", 32'(alarm), 32'(exp_alarm));
         if (bus.out_valid && bus.out_ready) begin
            if (q_sum.size() == 0) begin
               chk("unexpected_out", 32'(q_sum.size()), 1);
            end else begin
               e    = q_err.pop_front();
               have = 1'b1;
               chk("out_sum", 32'(bus.out_sum), 32'(q_sum.pop_front()));
               chk("out_err", 32'(bus.out_err), 32'(e));
            end
            n_out++;
         end
         if (clr) begin
            exp_cnt   = 0;
            consec    = 0;
            exp_alarm = 1'b0;
         end else if (have) begin
            if (e) begin
               if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
               consec++;
               if (consec >= THRESH) exp_alarm = 1'b1;
            end else begin
               consec = 0;
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            q_sum.push_back(bus.sum);
            q_err.push_back(model_err(bus.a, bus.b, bus.sum));
            n_in++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] s);
      int t;
      t = 0;
      bus.in_valid = 1'b1;
      bus.a        = a;
      bus.b        = b;
      bus.sum      = s;
      #1;
      while (!bus.in_ready && t < 50) begin
         step();
         #1;
         t++;
      end
      chk("send_timeout", 32'(t < 50), 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   initial begin
      logic [W:0]   held;
      logic [W-1:0] ra, rb;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.sum       = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_sum", 32'(bus.out_sum), 0);
      chk("rst_out_err", 32'(bus.out_err), 0);
      chk("rst_alarm", 32'(alarm), 0);
      chk("rst_err_cnt", 32'(err_cnt), 0);
      chk("rst_in_ready", 32'(bus.in_ready), 1);
      rst_n = 1'b1;
      step();

      // Clean add and two-cycle latency
      send(8'h05, 8'h03, 9'h008);
      chk("lat1_out_valid", 32'(bus.out_valid), 0);
      step();
      chk("lat2_out_valid", 32'(bus.out_valid), 1);
      chk("lat2_out_sum", 32'(bus.out_sum), 32'h008);
      chk("lat2_out_err", 32'(bus.out_err), 0);
      step();

      send(8'h80, 8'h80, 9'h100);
      step();
      chk("neg_out_err", 32'(bus.out_err), 0);
      step();
      chk("neg_err_cnt", 32'(err_cnt), 0);

      // Single fault, then recovery
      send(8'h7F, 8'h01, 9'h081);
      step();
      chk("fault_out_err", 32'(bus.out_err), 1);
      step();
      chk("fault_err_cnt", 32'(err_cnt), 1);
      chk("fault_alarm", 32'(alarm), 0);
      send(8'h10, 8'h20, 9'h030);
      step();
      step();

      // Back-pressure
      bus.out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         send(ra, rb, good_sum(ra, rb));
      end
      held = bus.out_sum;
      for (int i = 0; i < 3; i++) begin
         chk("bp_in_ready", 32'(bus.in_ready), 0);
         chk("bp_out_valid", 32'(bus.out_valid), 1);
         chk("bp_out_sum_stable", 32'(bus.out_sum), 32'(held));
         step();
      end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         send(ra, rb, good_sum(ra, rb));
      end
      repeat (4) step();
      chk("bp_drained", 32'(q_sum.size()), 0);
      chk("bp_count", 32'(n_out), 32'(n_in));

      // Alarm after three consecutive faults
      clr = 1'b1;
      step();
      clr = 1'b0;
      send(8'h01, 8'h02, 9'h004);
      send(8'hF0, 8'h05, 9'h1F6);
      send(8'h40, 8'h40, 9'h081);
      step();
      chk("alarm_before", 32'(alarm), 0);
      step();
      chk("alarm_after", 32'(alarm), 1);
      chk("alarm_err_cnt", 32'(err_cnt), 3);
      send(8'h11, 8'h22, 9'h033);
      send(8'hFF, 8'hFF, 9'h1FE);
      repeat (3) step();
      chk("alarm_sticky", 32'(alarm), 1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clr_alarm", 32'(alarm), 0);
      chk("clr_err_cnt", 32'(err_cnt), 0);

      // clr coincident with an erroneous handshake
      send(8'h05, 8'h03, 9'h009);
      step();
      chk("clrhs_out_valid", 32'(bus.out_valid), 1);
      chk("clrhs_out_err", 32'(bus.out_err), 1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clrhs_err_cnt", 32'(err_cnt), 0);
      step();

      // Error that is a multiple of three goes unnoticed
      send(8'h05, 8'h03, 9'h00B);
      step();
      chk("res3_limit_out_err", 32'(bus.out_err), 0);
      step();

      // Reset with both stages full
      bus.out_ready = 1'b0;
      send(8'h01, 8'h01, 9'h002);
      send(8'h02, 8'h02, 9'h004);
      chk("full_out_valid", 32'(bus.out_valid), 1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 32'(bus.out_valid), 0);
      n_in      = n_in - q_sum.size();
      q_sum.delete();
      q_err.delete();
      exp_cnt   = 0;
      consec    = 0;
      exp_alarm = 1'b0;
      step();
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("post_rst_out_valid", 32'(bus.out_valid), 0);
      end

      // Randomized traffic with random faults, back-pressure and clears
      for (int i = 0; i < 400; i++) begin
         int d;
         ra            = 8'($urandom);
         rb            = 8'($urandom);
         d             = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
         bus.a         = ra;
         bus.b         = rb;
         bus.sum       = good_sum(ra, rb) + 9'(d);
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         clr           = ($urandom_range(0, 40) == 0);
         step();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      clr           = 1'b0;
      repeat (6) step();
      chk("final_drained", 32'(q_sum.size()), 0);
      chk("final_count", 32'(n_out), 32'(n_in));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
